seq_detect_mux: RTL

Parametrised serial pattern detector with a held output select. Watches a qualified serial bit stream for a runtime-loadable PAT_W-bit pattern, in overlapping or non-overlapping mode. On each match it pulses `hit` and drives `res` from operand `a` for HOLD_LEN cycles, otherwise from operand `b`. It sits between the serial front end and the datapath mux stage, and generalises the team's fixed 4-state sequence detector.

---
 rtl/seq_detect_mux_if.sv | 28 ++
 rtl/seq_detect_mux.sv | 83 ++++++++
 2 files changed

// File: rtl/seq_detect_mux_if.sv
// seq_detect_mux_if: serial input, config, operand and result bundle for seq_detect_mux.
interface seq_detect_mux_if #(
    parameter int PAT_W  = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    logic              in_valid;
    logic              in_bit;
    logic              cfg_load;
    logic [PAT_W-1:0]  cfg_pat;
    logic              cfg_ovl;
    logic              cnt_clr;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] res;
    logic              hit;
    logic [CNT_W-1:0]  hit_cnt;

    modport master (
        output in_valid, in_bit, cfg_load, cfg_pat, cfg_ovl, cnt_clr, a, b,
        input  res, hit, hit_cnt
    );

    modport slave (
        input  in_valid, in_bit, cfg_load, cfg_pat, cfg_ovl, cnt_clr, a, b,
        output res, hit, hit_cnt
    );
endinterface

// File: rtl/seq_detect_mux.sv
// seq_detect_mux: serial pattern detector driving a held a/b select; hit counter built only with SEQDET_HITCNT_EN.
module seq_detect_mux #(
    parameter int               PAT_W    = 4,
    parameter int               DATA_W   = 8,
    parameter int               CNT_W    = 8,
    parameter int               HOLD_LEN = 2,
    parameter logic [PAT_W-1:0] PAT_INIT = 'b1101
) (
    input logic              clk,
    input logic              rst,
    seq_detect_mux_if.slave  bus
);
    localparam int FW = $clog2(PAT_W + 1);
    localparam int HW = $clog2(HOLD_LEN + 1);
    localparam logic [1:0] EMPTY   = 2'd0;
    localparam logic [1:0] FILLING = 2'd1;
    localparam logic [1:0] ARMED   = 2'd2;

    logic [PAT_W-1:0] pat_q, pat_d, hist_q, hist_d, acc_hist;
    logic             ovl_q, ovl_d, hit_q, hit_d, match, count_hit;
    logic [FW-1:0]    fill_q, fill_d, acc_fill;
    logic [HW-1:0]    hold_q, hold_d;
    logic [1:0]       state;

    // the FSM state is a view of the fill level
    assign state = (fill_q == '0) ? EMPTY : (fill_q == FW'(PAT_W)) ? ARMED : FILLING;

    always_comb begin
        acc_hist  = (hist_q << 1) | PAT_W'(bus.in_bit);
        acc_fill  = (state == ARMED) ? FW'(PAT_W) : fill_q + FW'(1);
        match     = bus.in_valid && (acc_fill == FW'(PAT_W)) && (acc_hist == pat_q);
        count_hit = match && !bus.cfg_load;
        pat_d     = bus.cfg_load ? bus.cfg_pat : pat_q;
        ovl_d     = bus.cfg_load ? bus.cfg_ovl : ovl_q;
        hit_d     = count_hit;
        hist_d    = bus.cfg_load ? '0 : bus.in_valid ? acc_hist : hist_q;
        fill_d    = bus.cfg_load ? '0 :
                    !bus.in_valid ? fill_q :
                    (match && !ovl_q) ? '0 : acc_fill;
        hold_d    = bus.cfg_load ? '0 :
                    count_hit ? HW'(HOLD_LEN) :
                    (hold_q != '0) ? hold_q - HW'(1) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q  <= PAT_INIT;
            ovl_q  <= 1'b0;
            hist_q <= '0;
            fill_q <= '0;
            hold_q <= '0;
            hit_q  <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            ovl_q  <= ovl_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            hold_q <= hold_d;
            hit_q  <= hit_d;
        end
    end

    assign bus.hit = hit_q;
    assign bus.res = (hold_q != '0) ? bus.a : bus.b;

`ifdef SEQDET_HITCNT_EN
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;

    always_comb hit_cnt_d = bus.cnt_clr ? '0 :
                            (count_hit && hit_cnt_q != '1) ? hit_cnt_q + CNT_W'(1) : hit_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) hit_cnt_q <= '0;
        else     hit_cnt_q <= hit_cnt_d;
    end

    assign bus.hit_cnt = hit_cnt_q;
`else
    logic unused_cnt;
    assign unused_cnt  = bus.cnt_clr;
    assign bus.hit_cnt = '0;
`endif
endmodule
